// File: rtl/hp2vga_pkg.sv
// Shared HP2VGA definitions: capture FSM states, default video geometry, BRAM shape.
package hp2vga_pkg;

  localparam int unsigned BRAM_AW = 14;
  localparam int unsigned BRAM_DW = 8;

  localparam int unsigned DEF_CLK_HZ    = 20_000_000;
  localparam int unsigned DEF_H_START   = 64;
  localparam int unsigned DEF_H_ACTIVE  = 512;
  localparam int unsigned DEF_V_START   = 16;
  localparam int unsigned DEF_V_ACTIVE  = 256;
  localparam logic [9:0]  DEF_THRESHOLD = 10'd512;

  typedef enum logic [2:0] {
    IDLE,
    VBLANK,
    HWAIT,
    ACTIVE,
    LDONE,
    FDONE
  } rx_state_e;

endpackage

// File: rtl/rx_capture_if.sv
// BRAM write port between the capture stage and the line-buffer BRAM.
interface rx_capture_if;
  import hp2vga_pkg::*;

  logic [BRAM_AW-1:0] BRAM_ADDR;
  logic [BRAM_DW-1:0] BRAM_DIN;
  logic               BRAM_WE;

  modport master (output BRAM_ADDR, output BRAM_DIN, output BRAM_WE);
  modport slave  (input  BRAM_ADDR, input  BRAM_DIN, input  BRAM_WE);
endinterface

// File: rtl/pixel_packer.sv
// Serial 1-bit pixel packer: MSB-first shift, registered byte with a one-cycle valid strobe.
module pixel_packer
  import hp2vga_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               shift_en_i,
  input  logic               bit_i,
  output logic [BRAM_DW-1:0] byte_o,
  output logic               valid_o
);
  localparam int unsigned CW = $clog2(BRAM_DW);

  logic [BRAM_DW-1:0] shift_q, shift_d;
  logic [BRAM_DW-1:0] byte_q;
  logic [CW-1:0]      cnt_q;
  logic               valid_q;
  logic               last;

  always_comb begin
    shift_d = {shift_q[BRAM_DW-2:0], bit_i};
    last    = (cnt_q == CW'(BRAM_DW - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (shift_en_i) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_q + 1'b1;
      valid_q <= last;
      if (last) byte_q <= shift_d;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/rx_capture.sv
// HP scope video capture: sync time-base, active-window thresholding, byte packing into BRAM.
module rx_capture
  import hp2vga_pkg::*;
#(
  parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
  parameter int unsigned H_START   = DEF_H_START,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned V_START   = DEF_V_START,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter logic [9:0]  THRESHOLD = DEF_THRESHOLD
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         ENABLE,
  input  logic         O_HS,
  input  logic         O_VS,
  input  logic [9:0]   VIDEO,
  rx_capture_if.master bram,
  output logic         SYNC,
  output logic         LOCKED,
  output logic         PULSE_1HZ
);
  localparam int unsigned BPL = H_ACTIVE / 8;

  logic hs_q, hs_p_q, vs_q, vs_p_q, en_q;
  logic [9:0] video_q;
  logic hs_rise, vs_rise, pix_bit;

  rx_state_e state_q, state_d;
  logic shift_en, pk_clr, abort, line_adv, line_last;

  logic [15:0]        cnt_q, cnt_d, vcnt_q, vcnt_d, line_q, line_d;
  logic [BRAM_AW-1:0] addr_q, addr_d;
  logic               locked_q, locked_d, sync_q;
  logic [31:0]        hb_q, hb_d;

  logic [BRAM_DW-1:0] pk_byte;
  logic               pk_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hs_q    <= 1'b0;
      hs_p_q  <= 1'b0;
      vs_q    <= 1'b0;
      vs_p_q  <= 1'b0;
      en_q    <= 1'b0;
      video_q <= '0;
    end else begin
      hs_q    <= O_HS;
      hs_p_q  <= hs_q;
      vs_q    <= O_VS;
      vs_p_q  <= vs_q;
      en_q    <= ENABLE;
      video_q <= VIDEO;
    end
  end

  always_comb begin
    hs_rise   = hs_q & ~hs_p_q;
    vs_rise   = vs_q & ~vs_p_q;
    pix_bit   = (video_q >= THRESHOLD);
    line_last = (line_q == 16'(V_ACTIVE - 1));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // VS is checked first so it wins over a coincident HS edge in every state.
  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      state_d = VBLANK;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        VBLANK:  if (hs_rise && vcnt_q == 16'(V_START - 1)) state_d = HWAIT;
        HWAIT:   if (cnt_q == 16'(H_START - 1)) state_d = ACTIVE;
        ACTIVE: begin
          if (hs_rise)                           state_d = line_last ? FDONE : HWAIT;
          else if (cnt_q == 16'(H_ACTIVE - 1))   state_d = LDONE;
        end
        LDONE:   if (hs_rise) state_d = line_last ? FDONE : HWAIT;
        FDONE:   state_d = FDONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    abort    = vs_rise && (state_q != IDLE) && (state_q != FDONE);
    line_adv = !vs_rise && hs_rise && (state_q == ACTIVE || state_q == LDONE);
    shift_en = (state_q == ACTIVE) && !vs_rise && !hs_rise;
    pk_clr   = abort || (state_q == ACTIVE && line_adv);
  end

  always_comb begin
    cnt_d    = cnt_q;
    vcnt_d   = vcnt_q;
    line_d   = line_q;
    addr_d   = addr_q;
    locked_d = locked_q;

    if (state_d != state_q)                           cnt_d = '0;
    else if (state_q == HWAIT || state_q == ACTIVE)   cnt_d = cnt_q + 16'd1;

    if (vs_rise)                                      vcnt_d = '0;
    else if (state_q == VBLANK && hs_rise)            vcnt_d = vcnt_q + 16'd1;

    if (vs_rise)       line_d = '0;
    else if (line_adv) line_d = line_q + 16'd1;

    // Address is latched alongside the 8th shift so it lines up with the packer's strobe.
    if (shift_en && cnt_q[2:0] == 3'd7)
      addr_d = BRAM_AW'(32'(line_q) * BPL + 32'(cnt_q >> 3));

    if (abort)                                        locked_d = 1'b0;
    else if (state_d == FDONE && state_q != FDONE)    locked_d = 1'b1;

    hb_d = (hb_q == CLK_HZ - 1) ? '0 : hb_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      vcnt_q   <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      locked_q <= 1'b0;
      sync_q   <= 1'b0;
      hb_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      vcnt_q   <= vcnt_d;
      line_q   <= line_d;
      addr_q   <= addr_d;
      locked_q <= locked_d;
      sync_q   <= vs_rise;
      hb_q     <= hb_d;
    end
  end

  pixel_packer u_packer (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .clr_i      (pk_clr),
    .shift_en_i (shift_en),
    .bit_i      (pix_bit),
    .byte_o     (pk_byte),
    .valid_o    (pk_valid)
  );

  assign bram.BRAM_ADDR = addr_q;
  assign bram.BRAM_DIN  = pk_byte;
  assign bram.BRAM_WE   = pk_valid & en_q;
  assign SYNC           = sync_q;
  assign LOCKED         = locked_q;
  assign PULSE_1HZ      = (hb_q == CLK_HZ - 1);
endmodule

// File: tb/tb_rx_capture.sv
// Directed bench for rx_capture with a small 16x4 geometry and a 100-cycle heartbeat.
module tb_rx_capture;
  import hp2vga_pkg::*;

  localparam int unsigned HZ = 100;
  localparam int unsigned HS = 4;
  localparam int unsigned HA = 16;
  localparam int unsigned VS = 2;
  localparam int unsigned VA = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       o_hs = 1'b0;
  logic       o_vs = 1'b0;
  logic [9:0] video = '0;
  logic       sync, locked, pulse;

  rx_capture_if bif ();

  rx_capture #(
    .CLK_HZ   (HZ),
    .H_START  (HS),
    .H_ACTIVE (HA),
    .V_START  (VS),
    .V_ACTIVE (VA),
    .THRESHOLD(10'd512)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .ENABLE   (enable),
    .O_HS     (o_hs),
    .O_VS     (o_vs),
    .VIDEO    (video),
    .bram     (bif),
    .SYNC     (sync),
    .LOCKED   (locked),
    .PULSE_1HZ(pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vs_cyc = 0;
  int sync_cyc = -1;
  logic [13:0] wa[$];
  logic [7:0]  wd[$];
  logic [9:0]  line_pix[16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bif.BRAM_WE) begin
      wa.push_back(bif.BRAM_ADDR);
      wd.push_back(bif.BRAM_DIN);
    end
    if (sync) sync_cyc = cyc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d, required finish before", cyc);
    $fatal(1);
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // HS rises now; pixel p of the line is driven after edge HS+1+p; next HS follows after len edges.
  task automatic send_line(input int unsigned n_pix, input int unsigned len);
    o_hs  = 1'b1;
    video = '0;
    for (int unsigned c = 1; c <= len; c++) begin
      tick(1);
      if (c == 2) o_hs = 1'b0;
      if (c >= HS + 1 && (c - (HS + 1)) < n_pix) video = line_pix[c - (HS + 1)];
      else video = '0;
    end
  endtask

  task automatic send_vs();
    o_vs   = 1'b1;
    vs_cyc = cyc;
    tick(3);
    o_vs = 1'b0;
    tick(4);
  endtask

  task automatic send_body(input int unsigned short_idx);
    send_line(0, 24);
    for (int unsigned l = 0; l < VA; l++) begin
      if (l == short_idx) send_line(10, 15);
      else                send_line(16, 24);
    end
    send_line(0, 24);
    tick(4);
  endtask

  task automatic set_geom();
    for (int i = 0; i < 16; i++) line_pix[i] = 10'd0;
    line_pix[0]  = 10'd1023;
    line_pix[15] = 10'd1023;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (bif.BRAM_WE !== 1'b0)   begin errors++; $display("FAIL rst_we got %b want 0", bif.BRAM_WE); end
    checks++; if (bif.BRAM_ADDR !== 14'd0) begin errors++; $display("FAIL rst_addr got %0h want 0", bif.BRAM_ADDR); end
    checks++; if (bif.BRAM_DIN !== 8'd0)  begin errors++; $display("FAIL rst_din got %0h want 0", bif.BRAM_DIN); end
    checks++; if (sync !== 1'b0)          begin errors++; $display("FAIL rst_sync got %b want 0", sync); end
    checks++; if (locked !== 1'b0)        begin errors++; $display("FAIL rst_locked got %b want 0", locked); end
    checks++; if (pulse !== 1'b0)         begin errors++; $display("FAIL rst_pulse got %b want 0", pulse); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_heartbeat();
    for (int n = 1; n <= 300; n++) begin
      logic exp;
      tick(1);
      exp = ((n % 100) == 99);
      checks++;
      if (pulse !== exp) begin
        errors++;
        $display("FAIL heartbeat cycle %0d got %b want %b", n, pulse, exp);
      end
    end
  endtask

  task automatic test_geometry();
    enable = 1'b1;
    set_geom();
    clear_log();
    send_vs();
    send_body(VA);
    checks++; if (wa.size() != 8) begin errors++; $display("FAIL geom_count got %0d want 8", wa.size()); end
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      logic [7:0] ed;
      ed = (i % 2 == 0) ? 8'h80 : 8'h01;
      checks++; if (wa[i] !== 14'(i)) begin errors++; $display("FAIL geom_addr%0d got %0h want %0h", i, wa[i], i); end
      checks++; if (wd[i] !== ed)     begin errors++; $display("FAIL geom_data%0d got %0h want %0h", i, wd[i], ed); end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL geom_locked got %b want 1", locked); end
    checks++; if (sync_cyc - vs_cyc != 2) begin errors++; $display("FAIL geom_sync_lat got %0d want 2", sync_cyc - vs_cyc); end
  endtask

  task automatic test_threshold();
    for (int i = 0; i < 16; i++) line_pix[i] = (i % 2 == 0) ? 10'd511 : 10'd512;
    clear_log();
    send_vs();
    send_body(VA);
    checks++; if (wa.size() != 8) begin errors++; $display("FAIL thr_count got %0d want 8", wa.size()); end
    for (int i = 0; i < wd.size() && i < 8; i++) begin
      checks++; if (wd[i] !== 8'h55) begin errors++; $display("FAIL thr_data%0d got %0h want 55", i, wd[i]); end
    end
  endtask

  task automatic test_abort();
    set_geom();
    clear_log();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL abort_pre_locked got %b want 1", locked); end
    send_vs();
    send_line(0, 24);
    send_line(16, 24);
    send_line(16, 24);
    send_line(10, 15);
    o_vs   = 1'b1;
    vs_cyc = cyc;
    tick(3);
    o_vs = 1'b0;
    tick(40);
    checks++; if (wa.size() != 5) begin errors++; $display("FAIL abort_count got %0d want 5", wa.size()); end
    checks++; if (wa[4] !== 14'd4) begin errors++; $display("FAIL abort_last_addr got %0h want 4", wa[4]); end
    checks++; if (wd[4] !== 8'h80) begin errors++; $display("FAIL abort_last_data got %0h want 80", wd[4]); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL abort_locked got %b want 0", locked); end
    checks++; if (sync_cyc - vs_cyc != 2) begin errors++; $display("FAIL abort_sync_lat got %0d want 2", sync_cyc - vs_cyc); end
    clear_log();
    send_vs();
    send_body(VA);
    checks++; if (wa.size() != 8) begin errors++; $display("FAIL restart_count got %0d want 8", wa.size()); end
    checks++; if (wa[0] !== 14'd0) begin errors++; $display("FAIL restart_addr got %0h want 0", wa[0]); end
    checks++; if (wd[0] !== 8'h80) begin errors++; $display("FAIL restart_data got %0h want 80", wd[0]); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL restart_locked got %b want 1", locked); end
  endtask

  task automatic test_enable_low();
    set_geom();
    enable = 1'b0;
    clear_log();
    send_vs();
    send_vs();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL en_vblank_abort_locked got %b want 0", locked); end
    checks++; if (sync_cyc - vs_cyc != 2) begin errors++; $display("FAIL en_sync_lat got %0d want 2", sync_cyc - vs_cyc); end
    send_body(VA);
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL en_writes got %0d want 0", wa.size()); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL en_locked got %b want 1", locked); end
    enable = 1'b1;
  endtask

  task automatic test_short_line();
    logic [13:0] ea[7] = '{14'd0, 14'd1, 14'd2, 14'd4, 14'd5, 14'd6, 14'd7};
    logic [7:0]  ed[7] = '{8'h80, 8'h01, 8'h80, 8'h80, 8'h01, 8'h80, 8'h01};
    set_geom();
    clear_log();
    send_vs();
    send_body(1);
    checks++; if (wa.size() != 7) begin errors++; $display("FAIL short_count got %0d want 7", wa.size()); end
    for (int i = 0; i < wa.size() && i < 7; i++) begin
      checks++; if (wa[i] !== ea[i]) begin errors++; $display("FAIL short_addr%0d got %0h want %0h", i, wa[i], ea[i]); end
      checks++; if (wd[i] !== ed[i]) begin errors++; $display("FAIL short_data%0d got %0h want %0h", i, wd[i], ed[i]); end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL short_locked got %b want 1", locked); end
  endtask

  task automatic test_async_reset();
    set_geom();
    send_vs();
    send_line(0, 24);
    send_line(16, 24);
    send_line(16, 12);
    #2;
    checks++; if (locked !== 1'b1)         begin errors++; $display("FAIL ar_pre_locked got %b want 1", locked); end
    checks++; if (bif.BRAM_ADDR !== 14'd1) begin errors++; $display("FAIL ar_pre_addr got %0h want 1", bif.BRAM_ADDR); end
    rst_n = 1'b0;
    #1;
    checks++; if (bif.BRAM_WE !== 1'b0)    begin errors++; $display("FAIL ar_we got %b want 0", bif.BRAM_WE); end
    checks++; if (bif.BRAM_ADDR !== 14'd0) begin errors++; $display("FAIL ar_addr got %0h want 0", bif.BRAM_ADDR); end
    checks++; if (bif.BRAM_DIN !== 8'd0)   begin errors++; $display("FAIL ar_din got %0h want 0", bif.BRAM_DIN); end
    checks++; if (sync !== 1'b0)           begin errors++; $display("FAIL ar_sync got %b want 0", sync); end
    checks++; if (locked !== 1'b0)         begin errors++; $display("FAIL ar_locked got %b want 0", locked); end
    checks++; if (pulse !== 1'b0)          begin errors++; $display("FAIL ar_pulse got %b want 0", pulse); end
    #3;
    rst_n = 1'b1;
    tick(2);
    clear_log();
    send_vs();
    send_body(VA);
    checks++; if (wa.size() != 8) begin errors++; $display("FAIL ar_recover_count got %0d want 8", wa.size()); end
    checks++; if (wa[0] !== 14'd0) begin errors++; $display("FAIL ar_recover_addr got %0h want 0", wa[0]); end
    checks++; if (wd[0] !== 8'h80) begin errors++; $display("FAIL ar_recover_data got %0h want 80", wd[0]); end
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_geometry();
    test_threshold();
    test_abort();
    test_enable_low();
    test_short_line();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
